// File: rtl/rx_pkg.sv
// rx_pkg: shared definitions for the RMII receive frame controller.
//   rx_state_t  - controller FSM states
//   CRC_RESIDUE - value the crc32 output shows after a frame plus a valid FCS
//   FCS_BYTES   - trailing FCS length stripped before release
//   crc_dibit() - advances the reflected CRC-32 register by one dibit
package rx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      CHECK = 3'd2,
      DRAIN = 3'd3,
      SKIP  = 3'd4
   } rx_state_t;

   localparam logic [31:0] CRC_RESIDUE = 32'h38FB_2284;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;   // 0x04C11DB7 reflected
   localparam int          FCS_BYTES   = 4;

   // Bits enter LSB first: d[0] is the earlier bit on the wire.
   function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
      logic [31:0] c;
      c = crc;
      for (int b = 0; b < 2; b++) begin
         if (c[0] ^ d[b]) c = (c >> 1) ^ CRC_POLY;
         else             c = c >> 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32.sv
// crc32: Ethernet CRC-32 over a 2-bit LSB-first stream.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high restart
//   axiiv - dibit valid
//   axiid - dibit data
//   axiod - bit-reversed, inverted CRC register; reads CRC_RESIDUE after
//           a frame that ends with a correct FCS
// A dibit presented while rst is high is absorbed into the fresh CRC, so a
// controller holding this block in restart while idle still catches the
// first dibit of a frame.
module crc32
   import rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [1:0]  axiid,
   output logic [31:0] axiod
);

   logic [31:0] crc_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_reg <= axiiv ? crc_dibit(CRC_INIT, axiid) : CRC_INIT;
      end else if (axiiv) begin
         crc_reg <= crc_dibit(crc_reg, axiid);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_rev
         assign axiod[gi] = ~crc_reg[31 - gi];
      end
   endgenerate

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: receive-side frame controller for the RMII path.
// Assembles dibits into bytes, buffers the frame, checks CRC residue,
// byte alignment, minimum length and overflow, then streams the payload
// (FCS removed) downstream. Failing frames are dropped and counted.
// Parameters:
//   BUF_BYTES - frame buffer depth in bytes (power of two)
//   MIN_BYTES - minimum legal frame length including FCS
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   axiiv, axiid       - dibit stream in (valid, data)
//   axior              - downstream ready
//   axiov, axiod       - payload byte out (valid, data)
//   frame_ok/frame_bad - one-cycle verdict pulses
//   busy               - controller not idle
//   good_cnt/bad_cnt   - saturating frame counters
// Build option: define RXCTRL_STATS_EN to implement the counters; without
// it both counter outputs are constant zero.
module rx_frame_ctrl
   import rx_pkg::*;
#(
   parameter int BUF_BYTES = 2048,
   parameter int MIN_BYTES = 64
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [1:0]  axiid,
   input  logic        axior,
   output logic        axiov,
   output logic [7:0]  axiod,
   output logic        frame_ok,
   output logic        frame_bad,
   output logic        busy,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);

   localparam int AW = $clog2(BUF_BYTES);
   localparam logic [AW:0]   BUF_LIMIT = BUF_BYTES[AW:0];
   localparam logic [AW:0]   MIN_LIMIT = MIN_BYTES[AW:0];
   localparam logic [AW:0]   FCS_LEN   = FCS_BYTES[AW:0];
   localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

   rx_state_t     state_reg;
   logic [AW:0]   byte_cnt_reg;
   logic [AW:0]   rel_cnt_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [1:0]    dibit_cnt_reg;
   logic [5:0]    byte_reg;        // earlier three dibits of the current byte
   logic          ovf_reg;
   logic          pend_skip_reg;
   logic          axiiv_prev_reg;
   logic          axiov_reg;
   logic          frame_ok_reg;
   logic          frame_bad_reg;

   logic [31:0]   crc_out;
   logic          crc_rst;
   logic          frame_good;
   logic          handshake;

   logic [7:0]    mem [BUF_BYTES];
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;

   assign crc_rst = ~rst | (state_reg == IDLE) | (state_reg == SKIP);

   crc32 u_crc (
      .clk   (clk),
      .rst   (crc_rst),
      .axiiv (axiiv),
      .axiid (axiid),
      .axiod (crc_out)
   );

   // Evaluated in the first idle cycle after the frame; the crc32 register
   // already holds the whole frame at that point.
   assign frame_good = (crc_out == CRC_RESIDUE) && (dibit_cnt_reg == 2'd0) &&
                       (byte_cnt_reg >= MIN_LIMIT) && !ovf_reg;

   assign handshake = axiov_reg & axior;

   // Single-port buffer: writes while receiving, reads while releasing.
   // During DRAIN the next address is fetched on the handshake cycle and the
   // current one is re-read on a stall, which keeps axiod steady.
   always_comb begin
      ram_we    = (state_reg == RECV) && axiiv && (dibit_cnt_reg == 2'd3) &&
                  !ovf_reg && (byte_cnt_reg != BUF_LIMIT);
      ram_wdata = {axiid, byte_reg};
      ram_addr  = byte_cnt_reg[AW-1:0];
      if (state_reg == CHECK) begin
         ram_addr = '0;
      end else if (state_reg == DRAIN) begin
         ram_addr = handshake ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         byte_cnt_reg   <= '0;
         rel_cnt_reg    <= '0;
         rd_ptr_reg     <= '0;
         dibit_cnt_reg  <= 2'd0;
         byte_reg       <= 6'd0;
         ovf_reg        <= 1'b0;
         pend_skip_reg  <= 1'b0;
         axiiv_prev_reg <= 1'b1;   // a frame already running at release is ignored
         axiov_reg      <= 1'b0;
         frame_ok_reg   <= 1'b0;
         frame_bad_reg  <= 1'b0;
      end else begin
         axiiv_prev_reg <= axiiv;
         frame_ok_reg   <= 1'b0;
         frame_bad_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               pend_skip_reg <= 1'b0;
               // Start only on a rising axiiv so a frame is never joined midway.
               if (axiiv && !axiiv_prev_reg) begin
                  state_reg     <= RECV;
                  byte_cnt_reg  <= '0;
                  dibit_cnt_reg <= 2'd1;
                  byte_reg      <= {axiid, 4'b0000};
                  ovf_reg       <= 1'b0;
               end
            end
            RECV: begin
               if (axiiv) begin
                  // Shifting right places dibit k at bits [2k+1:2k] once the byte completes.
                  dibit_cnt_reg <= dibit_cnt_reg + 2'd1;
                  byte_reg      <= {axiid, byte_reg[5:2]};
                  if (dibit_cnt_reg == 2'd3) begin
                     if (ovf_reg || (byte_cnt_reg == BUF_LIMIT)) ovf_reg <= 1'b1;
                     else byte_cnt_reg <= byte_cnt_reg + CNT_ONE;
                  end
               end else begin
                  state_reg     <= CHECK;
                  frame_ok_reg  <= frame_good;
                  frame_bad_reg <= ~frame_good;
               end
            end
            CHECK: begin
               rd_ptr_reg  <= '0;
               rel_cnt_reg <= byte_cnt_reg - FCS_LEN;
               if (axiiv) pend_skip_reg <= 1'b1;
               if (frame_ok_reg) begin
                  state_reg <= DRAIN;
                  axiov_reg <= 1'b1;
               end else begin
                  state_reg <= IDLE;
               end
            end
            DRAIN: begin
               if (axiiv) pend_skip_reg <= 1'b1;
               if (handshake) begin
                  rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
                  rel_cnt_reg <= rel_cnt_reg - CNT_ONE;
                  if (rel_cnt_reg == CNT_ONE) begin
                     axiov_reg <= 1'b0;
                     state_reg <= (pend_skip_reg || axiiv) ? SKIP : IDLE;
                  end
               end
            end
            SKIP: begin
               if (!axiiv) begin
                  frame_bad_reg <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign axiov     = axiov_reg;
   assign axiod     = axiov_reg ? ram_rdata : 8'h00;
   assign frame_ok  = frame_ok_reg;
   assign frame_bad = frame_bad_reg;
   assign busy      = (state_reg != IDLE);

`ifdef RXCTRL_STATS_EN
   logic [15:0] good_cnt_reg;
   logic [15:0] bad_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         good_cnt_reg <= 16'h0000;
         bad_cnt_reg  <= 16'h0000;
      end else begin
         if (frame_ok_reg && (good_cnt_reg != 16'hFFFF)) good_cnt_reg <= good_cnt_reg + 16'd1;
         if (frame_bad_reg && (bad_cnt_reg != 16'hFFFF)) bad_cnt_reg <= bad_cnt_reg + 16'd1;
      end
   end

   assign good_cnt = good_cnt_reg;
   assign bad_cnt  = bad_cnt_reg;
`else
   assign good_cnt = 16'h0000;
   assign bad_cnt  = 16'h0000;
`endif

endmodule
